// File: rtl/alu_cmd_sequencer_if.sv
// Command and result valid/ready bundle for alu_cmd_sequencer.
// master drives commands and consumes results; slave is the sequencer.
`timescale 1ns/1ps
interface alu_cmd_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int SELW  = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [SELW-1:0]  cmd_sel;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             cmd_cin;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_ovf;
  logic [SELW-1:0]  res_sel;

  modport master (
    output cmd_valid, cmd_sel, cmd_a,
    output cmd_b, cmd_cin, res_ready,
    input  cmd_ready, res_valid,
    input  res_data, res_ovf, res_sel
  );

  modport slave (
    input  cmd_valid, cmd_sel, cmd_a,
    input  cmd_b, cmd_cin, res_ready,
    output cmd_ready, res_valid,
    output res_data, res_ovf, res_sel
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the 8-bit ALU: command FIFO, operand regs, result reg.
// Optional ALU_CMD_STATUS_EN adds res_zero/res_neg status flags.
`timescale 1ns/1ps
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int SELW  = 3
) (
  input  logic                     clock,
  input  logic                     reset_n,
  alu_cmd_sequencer_if.slave       bus,
  output logic [SELW-1:0]          alu_sel,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic                     alu_cin,
  input  logic [WIDTH-1:0]         alu_out,
  input  logic                     alu_ovf,
`ifdef ALU_CMD_STATUS_EN
  output logic                     res_zero,
  output logic                     res_neg,
`endif
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [SELW-1:0]  sel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
  } cmd_t;

  typedef enum logic {IDLE, EXEC} state_t;

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  state_t        state;
  logic          push;
  logic          pop;
  logic          ovf_ok;

  assign bus.cmd_ready = fifo_count != (AW+1)'(DEPTH);
  assign push = bus.cmd_valid && bus.cmd_ready;
  assign pop  = (state == IDLE) && (fifo_count != '0)
             && (!bus.res_valid || bus.res_ready);
  // only add/sub produce a defined carry
  assign ovf_ok = alu_sel[SELW-1:1] == '0;

  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= '{sel: bus.cmd_sel,
                       a:   bus.cmd_a,
                       b:   bus.cmd_b,
                       cin: bus.cmd_cin};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      alu_sel       <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_cin       <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_ovf   <= 1'b0;
      bus.res_sel   <= '0;
`ifdef ALU_CMD_STATUS_EN
      res_zero      <= 1'b0;
      res_neg       <= 1'b0;
`endif
    end else begin
      if (bus.res_valid && bus.res_ready)
        bus.res_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pop) begin
            alu_sel <= mem[rd_ptr].sel;
            alu_a   <= mem[rd_ptr].a;
            alu_b   <= mem[rd_ptr].b;
            alu_cin <= mem[rd_ptr].cin;
            state   <= EXEC;
          end
        end
        EXEC: begin
          bus.res_data  <= alu_out;
          bus.res_sel   <= alu_sel;
          bus.res_ovf   <= ovf_ok & alu_ovf;
          bus.res_valid <= 1'b1;
`ifdef ALU_CMD_STATUS_EN
          res_zero      <= alu_out == '0;
          res_neg       <= alu_out[WIDTH-1];
`endif
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural ALU model.
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int WIDTH = 8;
  localparam int SELW  = 3;

  typedef struct {
    logic [SELW-1:0]  sel;
    logic [WIDTH-1:0] data;
    logic             ovf;
    logic             zero;
    logic             neg;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic junk = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) junk <= ~junk;

  alu_cmd_sequencer_if #(.WIDTH(WIDTH), .SELW(SELW)) bus();

  logic [SELW-1:0]       alu_sel;
  logic [WIDTH-1:0]      alu_a;
  logic [WIDTH-1:0]      alu_b;
  logic                  alu_cin;
  logic [WIDTH-1:0]      alu_out;
  logic                  alu_ovf;
  logic [$clog2(DEPTH):0] fifo_count;
`ifdef ALU_CMD_STATUS_EN
  logic res_zero;
  logic res_neg;
`endif

  alu_cmd_sequencer #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .SELW(SELW)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus.slave),
    .alu_sel    (alu_sel),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cin    (alu_cin),
    .alu_out    (alu_out),
    .alu_ovf    (alu_ovf),
`ifdef ALU_CMD_STATUS_EN
    .res_zero   (res_zero),
    .res_neg    (res_neg),
`endif
    .fifo_count (fifo_count)
  );

  // {carry, result}; carry only meaningful for add/sub
  function automatic logic [WIDTH:0] ref_alu(
    input logic [SELW-1:0] s, input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b, input logic c);
    logic [WIDTH:0] r;
    case (s)
      3'd0: r = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
      3'd1: r = {1'b0, a} + {1'b0, ~b} + 1;
      3'd2: r = {1'b0, a & b};
      3'd3: r = {1'b0, a | b};
      3'd4: r = {1'b0, a ^ b};
      3'd5: r = {1'b0, ~a};
      3'd6: r = {1'b0, a << 1};
      default: r = {1'b0, a >> 1};
    endcase
    return r;
  endfunction

  // ALU stand-in; garbage carry for logic ops
  always_comb begin
    logic [WIDTH:0] r;
    r = ref_alu(alu_sel, alu_a, alu_b, alu_cin);
    alu_out = r[WIDTH-1:0];
    alu_ovf = (alu_sel < 3'd2) ? r[WIDTH] : junk;
  end

  function automatic exp_t model(
    input logic [SELW-1:0] s, input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b, input logic c);
    exp_t e;
    logic [WIDTH:0] r;
    r = ref_alu(s, a, b, c);
    e.sel  = s;
    e.data = r[WIDTH-1:0];
    e.ovf  = (s < 3'd2) ? r[WIDTH] : 1'b0;
    e.zero = r[WIDTH-1:0] == 0;
    e.neg  = r[WIDTH-1];
    return e;
  endfunction

  int total = 0;
  int bad = 0;
  exp_t exp_q[$];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, expv);
    end
  endtask

  // monitor / scoreboard
  int   cyc = 0;
  bit   rate_en = 0;
  bit   rate_prev = 0;
  int   last_hs = -1;
  bit   hold = 0;
  logic [WIDTH-1:0] h_data;
  logic             h_ovf;
  logic [SELW-1:0]  h_sel;

  always @(negedge clock) begin
    cyc++;
    if (rate_en && !rate_prev) last_hs = -1;
    rate_prev = rate_en;
    if (!reset_n) begin
      hold = 0;
    end else begin
      if (bus.res_valid && hold) begin
        check("hold_data", bus.res_data, h_data);
        check("hold_ovf", bus.res_ovf, h_ovf);
        check("hold_sel", bus.res_sel, h_sel);
      end
      if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got %0h want none",
                   bus.res_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("res_data", bus.res_data, e.data);
          check("res_ovf", bus.res_ovf, e.ovf);
          check("res_sel", bus.res_sel, e.sel);
`ifdef ALU_CMD_STATUS_EN
          check("res_zero", res_zero, e.zero);
          check("res_neg", res_neg, e.neg);
`endif
        end
        if (rate_en && last_hs >= 0)
          check("rate", cyc - last_hs, 2);
        last_hs = cyc;
      end
      hold   = bus.res_valid && !bus.res_ready;
      h_data = bus.res_data;
      h_ovf  = bus.res_ovf;
      h_sel  = bus.res_sel;
      if (bus.cmd_valid && bus.cmd_ready)
        exp_q.push_back(model(bus.cmd_sel, bus.cmd_a,
                              bus.cmd_b, bus.cmd_cin));
    end
  end

  // returns at posedge+1 after the accepting edge
  task automatic push_cmd(input logic [SELW-1:0] s,
                          input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b,
                          input logic c);
    bit ok;
    int n;
    bus.cmd_valid = 1'b1;
    bus.cmd_sel = s;
    bus.cmd_a = a;
    bus.cmd_b = b;
    bus.cmd_cin = c;
    n = 0;
    do begin
      @(negedge clock);
      ok = bus.cmd_ready;
      @(posedge clock);
      n++;
    end while (!ok && n < 200);
    #1;
    bus.cmd_valid = 1'b0;
    if (!ok) check("push_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    bus.res_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || bus.res_valid) && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (n >= 300) check("drain_timeout", exp_q.size(), 0);
    @(posedge clock);
    #1;
  endtask

  task automatic directed(input string name,
                          input logic [SELW-1:0] s,
                          input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b,
                          input logic c,
                          input logic [WIDTH-1:0] xd,
                          input logic xo);
    bus.res_ready = 1'b1;
    push_cmd(s, a, b, c);
    @(negedge clock);
    check({name, "_lat1"}, bus.res_valid, 0);
    @(negedge clock);
    check({name, "_lat2"}, bus.res_valid, 0);
    @(negedge clock);
    check({name, "_lat3"}, bus.res_valid, 1);
    check({name, "_data"}, bus.res_data, xd);
    check({name, "_ovf"}, bus.res_ovf, xo);
    check({name, "_sel"}, bus.res_sel, s);
    drain();
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_sel = '0;
    bus.cmd_a = '0;
    bus.cmd_b = '0;
    bus.cmd_cin = 1'b0;
    bus.res_ready = 1'b0;
    #1;
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_count", fifo_count, 0);
    check("rst_alu", {alu_sel, alu_a, alu_b, alu_cin}, 0);
    check("rst_res", {bus.res_data, bus.res_ovf, bus.res_sel}, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    directed("add", 3'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    directed("sub", 3'd1, 8'h01, 8'hAA, 1'b0, 8'h57, 1'b0);
    directed("and", 3'd2, 8'hA0, 8'hAA, 1'b0, 8'hA0, 1'b0);
    directed("addc", 3'd0, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0);
`ifdef ALU_CMD_STATUS_EN
    directed("xor", 3'd4, 8'h23, 8'h23, 1'b0, 8'h00, 1'b0);
    check("xor_zero", res_zero, 1);
    check("xor_neg", res_neg, 0);
    directed("not", 3'd5, 8'h0F, 8'h00, 1'b0, 8'hF0, 1'b0);
    check("not_neg", res_neg, 1);
    check("not_zero", res_zero, 0);
`endif

    // full FIFO plus one pending result under backpressure
    bus.res_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          push_cmd(3'(i), 8'(8'h11 * i), 8'(8'h35 + i), 1'b1);
      end
      begin
        int n;
        n = 0;
        while (fifo_count != 4 && n < 50) begin
          @(negedge clock);
          n++;
        end
        check("full_count", fifo_count, 4);
        check("full_ready", bus.cmd_ready, 0);
        check("full_pending", bus.res_valid, 1);
        repeat (3) @(negedge clock);
        check("full_still", fifo_count, 4);
        @(posedge clock);
        #1;
        rate_en = 1;
        bus.res_ready = 1'b1;
      end
    join
    drain();
    rate_en = 0;

    // reset while EXEC with another command buffered
    bus.res_ready = 1'b1;
    push_cmd(3'd0, 8'h12, 8'h34, 1'b0);
    push_cmd(3'd1, 8'h56, 8'h78, 1'b0);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", bus.res_valid, 0);
    check("mid_rst_ready", bus.cmd_ready, 1);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_alu_a", alu_a, 0);
    exp_q.delete();
    @(negedge clock);
    reset_n = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clock);
        if (bus.res_valid) seen++;
      end
      check("no_result_after_rst", seen, 0);
    end
    @(posedge clock);
    #1;

    // random traffic
    for (int i = 0; i < 500; i++) begin
      bus.cmd_valid = 1'($urandom_range(0, 1));
      bus.cmd_sel = 3'($urandom_range(0, 7));
      bus.cmd_a = 8'($urandom);
      bus.cmd_b = 8'($urandom);
      bus.cmd_cin = 1'($urandom_range(0, 1));
      bus.res_ready = ($urandom_range(0, 3) != 0);
      @(posedge clock);
      #1;
    end
    bus.cmd_valid = 1'b0;
    drain();
    check("final_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
